mmio_dot_engine: RTL and testbench

Signed 8-bit dot-product accumulator that consumes the 64-bit words leaving the MMIO-fed FIFO in the AFU datapath. It sits directly downstream of the FIFO. Each accepted word carries four operand pairs. It accumulates products over a fixed number of words, then presents one result on a valid/ready port that the AFU MMIO read logic drains.

---
 rtl/mmio_dot_engine.sv | 155 +++++++++++++++
 tb/tb_mmio_dot_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_dot_engine.sv
// Signed 8-bit four-lane dot-product accumulator fed from the MMIO FIFO.
// Sums WORDS words of lane products and hands one result off over a valid/ready port.
module mmio_dot_engine #(
    parameter int WORDS = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [15:0]      res_count
);
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             in_ready_r;
    logic [7:0]       word_cnt_r;
    logic             s1_valid_r;
    logic [3:0][15:0] prod_r;
    logic [3:0][15:0] prod_s;
    logic [17:0]      sum_s;
    logic [ACC_W-1:0] sum_ext_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] res_data_r;
    logic             res_valid_r;
    logic [15:0]      res_count_r;
    logic             accept_s;
    logic             last_word_s;
    logic             handoff_s;
    logic             drain_done_s;

    // Two's complement lanes are sign-extended so a plain 16-bit multiply is exact.
    function automatic logic [15:0] lane_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] a_ext;
        logic [15:0] b_ext;
        a_ext = {{8{a[7]}}, a};
        b_ext = {{8{b[7]}}, b};
        return a_ext * b_ext;
    endfunction

    assign accept_s     = in_valid & in_ready_r & ~clear;
    assign last_word_s  = (word_cnt_r == LAST_IDX);
    assign handoff_s    = (state_r == ST_HOLD) & res_valid_r & res_ready;
    assign drain_done_s = (state_r == ST_DRAIN) & ~s1_valid_r;

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_count = res_count_r;

    // Lane products of the word on the input bus
    always_comb begin
        prod_s    = {4{16'd0}};
        prod_s[0] = lane_mul(in_data[39:32], in_data[7:0]);
        prod_s[1] = lane_mul(in_data[47:40], in_data[15:8]);
        prod_s[2] = lane_mul(in_data[55:48], in_data[23:16]);
        prod_s[3] = lane_mul(in_data[63:56], in_data[31:24]);
    end

    // 18-bit sum of the registered products, sign-extended to the accumulator width
    always_comb begin
        sum_s = {{2{prod_r[0][15]}}, prod_r[0]} + {{2{prod_r[1][15]}}, prod_r[1]}
              + {{2{prod_r[2][15]}}, prod_r[2]} + {{2{prod_r[3][15]}}, prod_r[3]};
        sum_ext_s = {{(ACC_W-18){sum_s[17]}}, sum_s};
    end

    // Next-state selection; clear always returns to accumulation
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: if (accept_s && last_word_s) state_nxt_s = ST_DRAIN;
                          else state_nxt_s = ST_ACCUM;
                ST_DRAIN: if (!s1_valid_r) state_nxt_s = ST_HOLD;
                          else state_nxt_s = ST_DRAIN;
                ST_HOLD:  if (handoff_s) state_nxt_s = ST_ACCUM;
                          else state_nxt_s = ST_HOLD;
                default:  state_nxt_s = ST_ACCUM;
            endcase
        end
    end

    // State register, registered in_ready decode and word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ACCUM;
            in_ready_r <= 1'b1;
            word_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_ACCUM);
            if (clear) begin
                word_cnt_r <= 8'd0;
            end else if (accept_s) begin
                word_cnt_r <= last_word_s ? 8'd0 : word_cnt_r + 8'd1;
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    // Stage 1: capture products of an accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            prod_r     <= {4{16'd0}};
        end else if (clear) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                prod_r <= prod_s;
            end
        end
    end

    // Stage 2: modulo-2^ACC_W accumulation, flushed on clear or handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clear || handoff_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (s1_valid_r) begin
            acc_r <= acc_r + sum_ext_s;
        end
    end

    // Result port; res_data deliberately survives clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
            res_count_r <= 16'd0;
        end else if (clear) begin
            res_valid_r <= 1'b0;
        end else if (drain_done_s) begin
            res_data_r  <= acc_r;
            res_valid_r <= 1'b1;
        end else if (handoff_s) begin
            res_valid_r <= 1'b0;
            res_count_r <= res_count_r + 16'd1;
        end
    end
endmodule

// File: tb/tb_mmio_dot_engine.sv
// Self-checking bench for mmio_dot_engine: three instances (default, ACC_W=20, WORDS=1)
// checked against a lane-arithmetic reference model.
module tb_mmio_dot_engine;
    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        clear_s     [3];
    logic        in_valid_s  [3];
    logic        in_ready_s  [3];
    logic [63:0] in_data_s   [3];
    logic        res_valid_s [3];
    logic        res_ready_s [3];
    logic [31:0] res_data_s  [3];
    logic [15:0] res_count_s [3];
    logic [19:0] b_res_data_s;

    int          total = 0;
    int          bad = 0;
    longint      model_acc [3];
    logic [15:0] cnt_exp [3];

    always #5 clk_s = ~clk_s;

    mmio_dot_engine dut_a (
        .clk(clk_s), .rst(rst_s), .clear(clear_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]),
        .res_data(res_data_s[0]), .res_count(res_count_s[0])
    );

    mmio_dot_engine #(.WORDS(8), .ACC_W(20)) dut_b (
        .clk(clk_s), .rst(rst_s), .clear(clear_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]),
        .res_data(b_res_data_s), .res_count(res_count_s[1])
    );
    assign res_data_s[1] = {12'd0, b_res_data_s};

    mmio_dot_engine #(.WORDS(1), .ACC_W(32)) dut_c (
        .clk(clk_s), .rst(rst_s), .clear(clear_s[2]),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .in_data(in_data_s[2]),
        .res_valid(res_valid_s[2]), .res_ready(res_ready_s[2]),
        .res_data(res_data_s[2]), .res_count(res_count_s[2])
    );

    // Reference: sum of four signed lane products
    function automatic longint dotw(input logic [63:0] w);
        longint s;
        byte    a;
        byte    b;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a = w[32 + 8*i +: 8];
            b = w[8*i +: 8];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic logic [31:0] expect_val(input int u);
        logic [31:0] v;
        v = 32'(model_acc[u]);
        if (u == 1) v = v & 32'h000F_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic send(input int u, input logic [63:0] w);
        int t;
        t = 0;
        in_valid_s[u] = 1'b1;
        in_data_s[u]  = w;
        while (in_ready_s[u] !== 1'b1 && t < 50) begin
            @(negedge clk_s);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout unit=%0d in_ready=%b required=1", u, in_ready_s[u]);
        end
        @(negedge clk_s);
        model_acc[u] += dotw(w);
        in_valid_s[u] = 1'b0;
    endtask

    task automatic collect(input int u, input string name, output logic [31:0] got);
        int t;
        t = 0;
        res_ready_s[u] = 1'b1;
        while (res_valid_s[u] !== 1'b1 && t < 40) begin
            @(negedge clk_s);
            t++;
        end
        got = res_data_s[u];
        total++;
        if (res_valid_s[u] !== 1'b1 || got !== expect_val(u)) begin
            bad++;
            $display("FAIL %s_data unit=%0d valid=%b got=%h required=%h", name, u,
                     res_valid_s[u], got, expect_val(u));
        end
        @(negedge clk_s);
        cnt_exp[u] = cnt_exp[u] + 16'd1;
        model_acc[u] = 0;
        total++;
        if (res_count_s[u] !== cnt_exp[u] || res_valid_s[u] !== 1'b0 || in_ready_s[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s_handoff unit=%0d count=%h required=%h valid=%b in_ready=%b",
                     name, u, res_count_s[u], cnt_exp[u], res_valid_s[u], in_ready_s[u]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        for (int u = 0; u < 3; u++) begin
            total++;
            if (in_ready_s[u] !== 1'b1 || res_valid_s[u] !== 1'b0 ||
                res_count_s[u] !== 16'd0 || res_data_s[u] !== 32'd0) begin
                bad++;
                $display("FAIL reset_state unit=%0d in_ready=%b valid=%b count=%h data=%h required=1/0/0/0",
                         u, in_ready_s[u], res_valid_s[u], res_count_s[u], res_data_s[u]);
            end
        end
        for (int i = 0; i < 3; i++) send(0, rand_word());
        rst_s = 1'b1;
        @(negedge clk_s);
        rst_s = 1'b0;
        for (int u = 0; u < 3; u++) begin
            model_acc[u] = 0;
            cnt_exp[u]   = 16'd0;
        end
        total++;
        if (in_ready_s[0] !== 1'b1 || res_valid_s[0] !== 1'b0 || res_count_s[0] !== 16'd0) begin
            bad++;
            $display("FAIL midrun_reset in_ready=%b valid=%b count=%h required=1/0/0",
                     in_ready_s[0], res_valid_s[0], res_count_s[0]);
        end
        for (int i = 0; i < 8; i++) send(0, rand_word());
        collect(0, "after_reset", got);
    endtask

    task automatic test_basic();
        logic [31:0] got;
        res_ready_s[0] = 1'b1;
        for (int i = 0; i < 8; i++) send(0, 64'h0101_0101_0202_0202);
        total++;
        if (in_ready_s[0] !== 1'b0 || res_valid_s[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain_k in_ready=%b valid=%b required=0/0", in_ready_s[0], res_valid_s[0]);
        end
        @(negedge clk_s);
        total++;
        if (res_valid_s[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_k1 got=%b required=0", res_valid_s[0]);
        end
        @(negedge clk_s);
        total++;
        if (res_valid_s[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_valid_k2 got=%b required=1", res_valid_s[0]);
        end
        collect(0, "basic", got);
        total++;
        if (got !== 32'h0000_0040 || res_count_s[0] !== 16'd2) begin
            bad++;
            $display("FAIL basic_const got=%h count=%h required=00000040/0002", got, res_count_s[0]);
        end
    endtask

    task automatic test_signed();
        logic [31:0] got;
        for (int i = 0; i < 8; i++) send(0, 64'h8080_8080_7F7F_7F7F);
        collect(0, "signed", got);
        total++;
        if (got !== 32'hFFF8_1000) begin
            bad++;
            $display("FAIL signed_const got=%h required=fff81000", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(2)) @(negedge clk_s);
                send(0, rand_word());
            end
            collect(0, "random", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        logic [31:0] held;
        logic [63:0] w0;
        int          t;
        res_ready_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, rand_word());
        t = 0;
        while (res_valid_s[0] !== 1'b1 && t < 20) begin
            @(negedge clk_s);
            t++;
        end
        held = res_data_s[0];
        total++;
        if (res_valid_s[0] !== 1'b1 || held !== expect_val(0)) begin
            bad++;
            $display("FAIL bp_result valid=%b got=%h required=%h", res_valid_s[0], held, expect_val(0));
        end
        w0 = rand_word();
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = w0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_s);
            total++;
            if (in_ready_s[0] !== 1'b0 || res_valid_s[0] !== 1'b1 || res_data_s[0] !== held) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d in_ready=%b valid=%b data=%h required=0/1/%h",
                         i, in_ready_s[0], res_valid_s[0], res_data_s[0], held);
            end
        end
        res_ready_s[0] = 1'b1;
        @(negedge clk_s);
        cnt_exp[0] = cnt_exp[0] + 16'd1;
        model_acc[0] = 0;
        total++;
        if (in_ready_s[0] !== 1'b1 || res_valid_s[0] !== 1'b0 || res_count_s[0] !== cnt_exp[0]) begin
            bad++;
            $display("FAIL bp_handoff in_ready=%b valid=%b count=%h required=1/0/%h",
                     in_ready_s[0], res_valid_s[0], res_count_s[0], cnt_exp[0]);
        end
        send(0, w0);
        for (int i = 0; i < 7; i++) send(0, rand_word());
        collect(0, "bp_next", got);
    endtask

    task automatic test_clear();
        logic [31:0] got;
        logic [31:0] held;
        int          t;
        res_ready_s[0] = 1'b1;
        for (int i = 0; i < 5; i++) send(0, rand_word());
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = rand_word();
        clear_s[0]    = 1'b1;
        @(negedge clk_s);
        clear_s[0]    = 1'b0;
        in_valid_s[0] = 1'b0;
        model_acc[0]  = 0;
        total++;
        if (in_ready_s[0] !== 1'b1 || res_valid_s[0] !== 1'b0 || res_count_s[0] !== cnt_exp[0]) begin
            bad++;
            $display("FAIL clear_state in_ready=%b valid=%b count=%h required=1/0/%h",
                     in_ready_s[0], res_valid_s[0], res_count_s[0], cnt_exp[0]);
        end
        for (int i = 0; i < 8; i++) send(0, 64'h0101_0101_0202_0202);
        collect(0, "clear_next", got);
        total++;
        if (got !== 32'h0000_0040) begin
            bad++;
            $display("FAIL clear_const got=%h required=00000040", got);
        end
        res_ready_s[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, rand_word());
        t = 0;
        while (res_valid_s[0] !== 1'b1 && t < 20) begin
            @(negedge clk_s);
            t++;
        end
        held = expect_val(0);
        clear_s[0]     = 1'b1;
        res_ready_s[0] = 1'b1;
        @(negedge clk_s);
        clear_s[0]     = 1'b0;
        res_ready_s[0] = 1'b0;
        model_acc[0]   = 0;
        total++;
        if (res_valid_s[0] !== 1'b0 || res_count_s[0] !== cnt_exp[0] || res_data_s[0] !== held) begin
            bad++;
            $display("FAIL clear_wins valid=%b count=%h data=%h required=0/%h/%h",
                     res_valid_s[0], res_count_s[0], res_data_s[0], cnt_exp[0], held);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        for (int i = 0; i < 8; i++) send(1, 64'h7F7F_7F7F_7F7F_7F7F);
        collect(1, "wrap", got);
        total++;
        if (got !== 32'h0007_E020) begin
            bad++;
            $display("FAIL wrap_const got=%h required=0007e020", got);
        end
        force dut_b.res_count_r = 16'hFFFF;
        @(negedge clk_s);
        release dut_b.res_count_r;
        cnt_exp[1] = 16'hFFFF;
        for (int i = 0; i < 8; i++) send(1, rand_word());
        collect(1, "count_wrap", got);
        total++;
        if (res_count_s[1] !== 16'h0000) begin
            bad++;
            $display("FAIL count_wrap_const got=%h required=0000", res_count_s[1]);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] got;
        res_ready_s[2] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            send(2, rand_word());
            total++;
            if (in_ready_s[2] !== 1'b0 || res_valid_s[2] !== 1'b0) begin
                bad++;
                $display("FAIL single_drain in_ready=%b valid=%b required=0/0", in_ready_s[2], res_valid_s[2]);
            end
            @(negedge clk_s);
            @(negedge clk_s);
            total++;
            if (res_valid_s[2] !== 1'b1) begin
                bad++;
                $display("FAIL single_latency valid=%b required=1", res_valid_s[2]);
            end
            collect(2, "single", got);
        end
    endtask

    initial begin
        rst_s = 1'b1;
        for (int u = 0; u < 3; u++) begin
            clear_s[u]     = 1'b0;
            in_valid_s[u]  = 1'b0;
            in_data_s[u]   = 64'd0;
            res_ready_s[u] = 1'b0;
            model_acc[u]   = 0;
            cnt_exp[u]     = 16'd0;
        end
        repeat (2) @(negedge clk_s);
        rst_s = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_random();
        test_backpressure();
        test_clear();
        test_wrap();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
